proc_multicycle_ctrl: RTL and testbench

//  Control FSM for the multicycle TinyRV1 processor. Sequences one shared datapath
//  and one shared memory port through fetch, execute, memory and multiply phases for
//  add, addi, mul, lw, sw, jal, jr and bne. Decodes the datapath's instruction register
//  and drives every enable and mux select. Pulses the retire strobe used by trace_val.

---
 rtl/tinyrv1_ctrl_pkg.sv | 58 +++++
 rtl/proc_multicycle_ctrl_if.sv | 36 +++
 rtl/tinyrv1_decoder.sv | 55 +++++
 rtl/proc_multicycle_ctrl.sv | 146 ++++++++++++++
 tb/tb_proc_multicycle_ctrl.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tinyrv1_ctrl_pkg.sv
// Shared definitions for the TinyRV1 multicycle controller: FSM states, instruction classes,
// opcode/funct fields, and the pc_sel / wb_sel / imm_type encodings seen by the datapath.
package tinyrv1_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StFetchWait,
    StExec,
    StMem,
    StMemWait,
    StMul,
    StHalt
  } state_e;

  typedef enum logic [3:0] {
    ClsAdd,
    ClsAddi,
    ClsMul,
    ClsLw,
    ClsSw,
    ClsJal,
    ClsJr,
    ClsBne,
    ClsIllegal
  } inst_cls_e;

  localparam logic [6:0] OpcReg    = 7'b0110011;
  localparam logic [6:0] OpcImm    = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  localparam logic [2:0] F3Add  = 3'b000;
  localparam logic [2:0] F3Word = 3'b010;
  localparam logic [2:0] F3Bne  = 3'b001;

  localparam logic [6:0] F7Add = 7'b0000000;
  localparam logic [6:0] F7Mul = 7'b0000001;

  localparam logic [1:0] PcSelPlus4 = 2'd0;
  localparam logic [1:0] PcSelJal   = 2'd1;
  localparam logic [1:0] PcSelJr    = 2'd2;
  localparam logic [1:0] PcSelBr    = 2'd3;

  localparam logic [1:0] WbSelAlu = 2'd0;
  localparam logic [1:0] WbSelMem = 2'd1;
  localparam logic [1:0] WbSelPc4 = 2'd2;
  localparam logic [1:0] WbSelMul = 2'd3;

  localparam logic [1:0] ImmI = 2'd0;
  localparam logic [1:0] ImmS = 2'd1;
  localparam logic [1:0] ImmB = 2'd2;
  localparam logic [1:0] ImmJ = 2'd3;

endpackage

// File: rtl/proc_multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller and its datapath + memory port.
//   master : controller view (drives enables/selects/memory request, reads status)
//   slave  : datapath/memory view (drives inst, br_ne, rdy/resp, mul_done)
interface proc_multicycle_ctrl_if;
  logic [31:0] inst;
  logic        br_ne;
  logic        mem_req_rdy;
  logic        mem_resp_val;
  logic        mul_done;
  logic        mem_req_val;
  logic        mem_req_wr;
  logic        mem_addr_sel;
  logic        ir_en;
  logic        pc_en;
  logic        pc_rst;
  logic [1:0]  pc_sel;
  logic        op2_sel;
  logic [1:0]  imm_type;
  logic        rf_wen;
  logic [1:0]  wb_sel;
  logic        mul_start;
  logic        retire;
  logic        halted;

  modport master (
    input  inst, br_ne, mem_req_rdy, mem_resp_val, mul_done,
    output mem_req_val, mem_req_wr, mem_addr_sel, ir_en, pc_en, pc_rst, pc_sel, op2_sel,
           imm_type, rf_wen, wb_sel, mul_start, retire, halted
  );

  modport slave (
    output inst, br_ne, mem_req_rdy, mem_resp_val, mul_done,
    input  mem_req_val, mem_req_wr, mem_addr_sel, ir_en, pc_en, pc_rst, pc_sel, op2_sel,
           imm_type, rf_wen, wb_sel, mul_start, retire, halted
  );
endinterface

// File: rtl/tinyrv1_decoder.sv
// Combinational TinyRV1 decoder.
//   inst_i     : instruction register contents
//   cls_o      : instruction class (ClsIllegal for anything not in the TinyRV1 subset)
//   rd_zero_o  : destination register is x0
//   imm_type_o : immediate format for the datapath immediate generator
module tinyrv1_decoder
  import tinyrv1_ctrl_pkg::*;
(
  input  logic [31:0] inst_i,
  output inst_cls_e   cls_o,
  output logic        rd_zero_o,
  output logic [1:0]  imm_type_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode    = inst_i[6:0];
  assign funct3    = inst_i[14:12];
  assign funct7    = inst_i[31:25];
  assign rd_zero_o = (inst_i[11:7] == 5'd0);

  // Register specifiers are consumed by the datapath only.
  logic unused_rs;
  assign unused_rs = ^inst_i[24:15];

  always_comb begin
    cls_o      = ClsIllegal;
    imm_type_o = ImmI;
    case (opcode)
      OpcReg: begin
        if (funct3 == F3Add && funct7 == F7Add) cls_o = ClsAdd;
        else if (funct3 == F3Add && funct7 == F7Mul) cls_o = ClsMul;
      end
      OpcImm:  if (funct3 == F3Add) cls_o = ClsAddi;
      OpcLoad: if (funct3 == F3Word) cls_o = ClsLw;
      OpcStore: begin
        if (funct3 == F3Word) cls_o = ClsSw;
        imm_type_o = ImmS;
      end
      OpcJal: begin
        cls_o      = ClsJal;
        imm_type_o = ImmJ;
      end
      OpcJalr: if (funct3 == F3Add) cls_o = ClsJr;
      OpcBranch: begin
        if (funct3 == F3Bne) cls_o = ClsBne;
        imm_type_o = ImmB;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/proc_multicycle_ctrl.sv
// Control FSM for the multicycle TinyRV1 core. Sequences the shared datapath and memory port
// through fetch / execute / memory / multiply phases and drives every enable and mux select.
//   clk   : clock
//   rst   : asynchronous active-low reset (returns to idle, PC held at RESET_PC)
//   dp_io : control/status bundle (master modport), see proc_multicycle_ctrl_if
module proc_multicycle_ctrl
  import tinyrv1_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          rst,
  proc_multicycle_ctrl_if.master        dp_io
);

  // The reset PC value lives in the datapath; the controller only asserts pc_rst.
  logic unused_reset_pc;
  assign unused_reset_pc = ^RESET_PC;

  state_e    state_q, state_d;
  inst_cls_e cls;
  logic      rd_zero;
  logic [1:0] dec_imm_type;
  logic      wen_ok;
  logic      op2_imm;

  tinyrv1_decoder u_decoder (
    .inst_i     (dp_io.inst),
    .cls_o      (cls),
    .rd_zero_o  (rd_zero),
    .imm_type_o (dec_imm_type)
  );

  assign wen_ok  = !rd_zero;
  assign op2_imm = (cls == ClsAddi) || (cls == ClsLw) || (cls == ClsSw);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d            = state_q;
    dp_io.mem_req_val  = 1'b0;
    dp_io.mem_req_wr   = 1'b0;
    dp_io.mem_addr_sel = 1'b0;
    dp_io.ir_en        = 1'b0;
    dp_io.pc_en        = 1'b0;
    dp_io.pc_rst       = 1'b0;
    dp_io.pc_sel       = PcSelPlus4;
    dp_io.op2_sel      = 1'b0;
    dp_io.imm_type     = ImmI;
    dp_io.rf_wen       = 1'b0;
    dp_io.wb_sel       = WbSelAlu;
    dp_io.mul_start    = 1'b0;
    dp_io.retire       = 1'b0;
    dp_io.halted       = 1'b0;

    unique case (state_q)
      StIdle: begin
        dp_io.pc_rst = 1'b1;
        state_d      = StFetch;
      end
      StFetch: begin
        dp_io.mem_req_val = 1'b1;
        if (dp_io.mem_req_rdy) state_d = StFetchWait;
      end
      StFetchWait: begin
        dp_io.ir_en = dp_io.mem_resp_val;
        if (dp_io.mem_resp_val) state_d = StExec;
      end
      StExec: begin
        dp_io.op2_sel  = op2_imm;
        dp_io.imm_type = dec_imm_type;
        unique case (cls)
          ClsAdd, ClsAddi: begin
            dp_io.rf_wen = wen_ok;
            dp_io.wb_sel = WbSelAlu;
            dp_io.pc_en  = 1'b1;
            dp_io.retire = 1'b1;
            state_d      = StFetch;
          end
          ClsJal: begin
            dp_io.rf_wen = wen_ok;
            dp_io.wb_sel = WbSelPc4;
            dp_io.pc_en  = 1'b1;
            dp_io.pc_sel = PcSelJal;
            dp_io.retire = 1'b1;
            state_d      = StFetch;
          end
          ClsJr: begin
            dp_io.pc_en  = 1'b1;
            dp_io.pc_sel = PcSelJr;
            dp_io.retire = 1'b1;
            state_d      = StFetch;
          end
          ClsBne: begin
            dp_io.pc_en  = 1'b1;
            dp_io.pc_sel = dp_io.br_ne ? PcSelBr : PcSelPlus4;
            dp_io.retire = 1'b1;
            state_d      = StFetch;
          end
          ClsLw, ClsSw: state_d = StMem;
          ClsMul: begin
            dp_io.mul_start = 1'b1;
            state_d         = StMul;
          end
          default: state_d = StHalt;
        endcase
      end
      StMem: begin
        dp_io.mem_req_val  = 1'b1;
        dp_io.mem_addr_sel = 1'b1;
        dp_io.mem_req_wr   = (cls == ClsSw);
        dp_io.op2_sel      = 1'b1;
        dp_io.imm_type     = dec_imm_type;
        if (dp_io.mem_req_rdy) state_d = StMemWait;
      end
      StMemWait: begin
        dp_io.op2_sel  = op2_imm;
        dp_io.imm_type = dec_imm_type;
        if (dp_io.mem_resp_val) begin
          if (cls == ClsLw) begin
            dp_io.rf_wen = wen_ok;
            dp_io.wb_sel = WbSelMem;
          end
          dp_io.pc_en  = 1'b1;
          dp_io.retire = 1'b1;
          state_d      = StFetch;
        end
      end
      StMul: begin
        if (dp_io.mul_done) begin
          dp_io.rf_wen = wen_ok;
          dp_io.wb_sel = WbSelMul;
          dp_io.pc_en  = 1'b1;
          dp_io.retire = 1'b1;
          state_d      = StFetch;
        end
      end
      StHalt: dp_io.halted = 1'b1;
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_proc_multicycle_ctrl.sv
module tb_proc_multicycle_ctrl;
  import tinyrv1_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  proc_multicycle_ctrl_if dp_if ();

  proc_multicycle_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst   (rst),
    .dp_io (dp_if)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic       wen;
    logic [1:0] wb;
    logic [1:0] pc;
    logic       op2;
    logic       wr;
    int         lat;
    int         mem_cyc;
  } exp_t;

  exp_t sb_q[$];

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    dp_if.inst         = 32'h0;
    dp_if.br_ne        = 1'b0;
    dp_if.mem_req_rdy  = 1'b0;
    dp_if.mem_resp_val = 1'b0;
    dp_if.mul_done     = 1'b0;
  endtask

  // Starts at a negedge with the DUT in FETCH; acts as a one-cycle-latency memory and an
  // N-cycle multiplier, and scoreboards the retiring cycle against the pushed expectation.
  task automatic run_inst(input string name, input logic [31:0] ins, input logic ne,
                          input int stall, input int mul_n, input exp_t e);
    exp_t x;
    int   cyc = 0;
    int   mem_cyc = 0;
    int   stall_left = stall;
    int   mul_left = 0;
    logic pend = 1'b0;
    bit   done = 1'b0;
    logic pend_n;
    sb_q.push_back(e);
    dp_if.inst  = ins;
    dp_if.br_ne = ne;
    while (!done && cyc < 40) begin
      cyc++;
      dp_if.mem_resp_val = pend;
      dp_if.mul_done     = (mul_left == 1);
      dp_if.mem_req_rdy  = 1'b1;
      if (dp_if.mem_req_val && dp_if.mem_addr_sel) begin
        mem_cyc++;
        if (stall_left > 0) begin
          dp_if.mem_req_rdy = 1'b0;
          stall_left--;
        end
        n_vec++;
        if (dp_if.mem_req_wr !== e.wr) begin
          n_err++;
          $display("FAIL %s mem_req_wr: got %b want %b", name, dp_if.mem_req_wr, e.wr);
        end
      end
      #1;
      if (cyc == 2) begin
        n_vec++;
        if (dp_if.ir_en !== 1'b1) begin
          n_err++;
          $display("FAIL %s ir_en in fetch_wait: got %b want 1", name, dp_if.ir_en);
        end
      end
      if (dp_if.retire === 1'b1) begin
        done = 1'b1;
        x = sb_q.pop_front();
        n_vec += 6;
        if (cyc != x.lat) begin
          n_err++;
          $display("FAIL %s latency: got %0d want %0d", name, cyc, x.lat);
        end
        if (dp_if.rf_wen !== x.wen) begin
          n_err++;
          $display("FAIL %s rf_wen: got %b want %b", name, dp_if.rf_wen, x.wen);
        end
        if (dp_if.wb_sel !== x.wb) begin
          n_err++;
          $display("FAIL %s wb_sel: got %0d want %0d", name, dp_if.wb_sel, x.wb);
        end
        if (dp_if.pc_sel !== x.pc || dp_if.pc_en !== 1'b1) begin
          n_err++;
          $display("FAIL %s pc_sel/pc_en: got %0d/%b want %0d/1", name, dp_if.pc_sel,
                   dp_if.pc_en, x.pc);
        end
        if (dp_if.op2_sel !== x.op2) begin
          n_err++;
          $display("FAIL %s op2_sel: got %b want %b", name, dp_if.op2_sel, x.op2);
        end
        if (mem_cyc != x.mem_cyc) begin
          n_err++;
          $display("FAIL %s data-request cycles: got %0d want %0d", name, mem_cyc, x.mem_cyc);
        end
      end
      pend_n = dp_if.mem_req_val && dp_if.mem_req_rdy;
      if (dp_if.mul_start === 1'b1) mul_left = mul_n;
      else if (mul_left > 0) mul_left--;
      next_cycle();
      pend = pend_n;
    end
    dp_if.mem_resp_val = 1'b0;
    dp_if.mul_done     = 1'b0;
    if (!done) begin
      x = sb_q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL %s retire timeout: got none in 40 cycles want cycle %0d", name, x.lat);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if (dp_if.pc_rst !== 1'b1 || dp_if.mem_req_val !== 1'b0 || dp_if.retire !== 1'b0 ||
          dp_if.pc_en !== 1'b0 || dp_if.rf_wen !== 1'b0 || dp_if.halted !== 1'b0) begin
        n_err++;
        $display("FAIL reset outputs: got pc_rst=%b req=%b ret=%b pc_en=%b wen=%b halt=%b want 1,0,0,0,0,0",
                 dp_if.pc_rst, dp_if.mem_req_val, dp_if.retire, dp_if.pc_en, dp_if.rf_wen,
                 dp_if.halted);
      end
      next_cycle();
    end
    rst = 1'b1;
    next_cycle();
    n_vec++;
    if (dp_if.mem_req_val !== 1'b1 || dp_if.pc_rst !== 1'b0 || dp_if.mem_addr_sel !== 1'b0) begin
      n_err++;
      $display("FAIL reset release fetch: got req=%b pc_rst=%b addr_sel=%b want 1,0,0",
               dp_if.mem_req_val, dp_if.pc_rst, dp_if.mem_addr_sel);
    end
  endtask

  task automatic test_alu();
    run_inst("addi_x1", 32'h0050_0093, 1'b0, 0, 0, '{1'b1, WbSelAlu, PcSelPlus4, 1'b1, 1'b0, 3, 0});
    run_inst("add_x3", 32'h0020_81b3, 1'b0, 0, 0, '{1'b1, WbSelAlu, PcSelPlus4, 1'b0, 1'b0, 3, 0});
    run_inst("addi_x0", 32'h0050_0013, 1'b0, 0, 0, '{1'b0, WbSelAlu, PcSelPlus4, 1'b1, 1'b0, 3, 0});
  endtask

  task automatic test_mem();
    run_inst("lw_stall2", 32'h0000_a103, 1'b0, 2, 0, '{1'b1, WbSelMem, PcSelPlus4, 1'b1, 1'b0, 7, 3});
    run_inst("sw", 32'h0020_a023, 1'b0, 0, 0, '{1'b0, WbSelAlu, PcSelPlus4, 1'b1, 1'b1, 5, 1});
    run_inst("lw", 32'h0000_a103, 1'b0, 0, 0, '{1'b1, WbSelMem, PcSelPlus4, 1'b1, 1'b0, 5, 1});
  endtask

  task automatic test_jump();
    run_inst("jal_x1", 32'h0080_00ef, 1'b0, 0, 0, '{1'b1, WbSelPc4, PcSelJal, 1'b0, 1'b0, 3, 0});
    run_inst("jal_x0", 32'h0080_006f, 1'b0, 0, 0, '{1'b0, WbSelPc4, PcSelJal, 1'b0, 1'b0, 3, 0});
    run_inst("jr_x1", 32'h0000_8067, 1'b0, 0, 0, '{1'b0, WbSelAlu, PcSelJr, 1'b0, 1'b0, 3, 0});
  endtask

  task automatic test_branch();
    run_inst("bne_taken", 32'h0020_9463, 1'b1, 0, 0, '{1'b0, WbSelAlu, PcSelBr, 1'b0, 1'b0, 3, 0});
    run_inst("bne_not", 32'h0020_9463, 1'b0, 0, 0, '{1'b0, WbSelAlu, PcSelPlus4, 1'b0, 1'b0, 3, 0});
  endtask

  task automatic test_mul();
    run_inst("mul_n4", 32'h0220_81b3, 1'b0, 0, 4, '{1'b1, WbSelMul, PcSelPlus4, 1'b0, 1'b0, 7, 0});
    run_inst("mul_n1", 32'h0220_81b3, 1'b0, 0, 1, '{1'b1, WbSelMul, PcSelPlus4, 1'b0, 1'b0, 4, 0});
  endtask

  task automatic test_back_to_back();
    run_inst("b2b_mul", 32'h0220_81b3, 1'b0, 0, 2, '{1'b1, WbSelMul, PcSelPlus4, 1'b0, 1'b0, 5, 0});
    run_inst("b2b_sw", 32'h0020_a023, 1'b0, 1, 0, '{1'b0, WbSelAlu, PcSelPlus4, 1'b1, 1'b1, 6, 2});
    run_inst("b2b_addi", 32'h0050_0093, 1'b0, 0, 0, '{1'b1, WbSelAlu, PcSelPlus4, 1'b1, 1'b0, 3, 0});
  endtask

  task automatic test_illegal();
    dp_if.inst        = 32'hFFFF_FFFF;
    dp_if.mem_req_rdy = 1'b1;
    next_cycle();
    dp_if.mem_resp_val = 1'b1;
    next_cycle();
    dp_if.mem_resp_val = 1'b0;
    #1;
    n_vec++;
    if (dp_if.retire !== 1'b0 || dp_if.pc_en !== 1'b0 || dp_if.rf_wen !== 1'b0 ||
        dp_if.mem_req_val !== 1'b0 || dp_if.mul_start !== 1'b0) begin
      n_err++;
      $display("FAIL illegal exec side effects: got ret=%b pc_en=%b wen=%b req=%b mul=%b want 0",
               dp_if.retire, dp_if.pc_en, dp_if.rf_wen, dp_if.mem_req_val, dp_if.mul_start);
    end
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      dp_if.mem_resp_val = 1'b1;
      dp_if.mul_done     = 1'b1;
      #1;
      n_vec++;
      if (dp_if.halted !== 1'b1 || dp_if.pc_en !== 1'b0 || dp_if.rf_wen !== 1'b0 ||
          dp_if.ir_en !== 1'b0 || dp_if.mem_req_val !== 1'b0 || dp_if.retire !== 1'b0) begin
        n_err++;
        $display("FAIL halt hold %0d: got halt=%b pc_en=%b wen=%b ir=%b req=%b ret=%b want 1,0,0,0,0,0",
                 i, dp_if.halted, dp_if.pc_en, dp_if.rf_wen, dp_if.ir_en, dp_if.mem_req_val,
                 dp_if.retire);
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    dp_if.inst        = 32'h0000_a103;
    dp_if.mem_req_rdy = 1'b1;
    next_cycle();
    dp_if.mem_resp_val = 1'b1;
    next_cycle();
    dp_if.mem_resp_val = 1'b0;
    next_cycle();
    next_cycle();
    // Now in MEM_WAIT with the load outstanding.
    dp_if.mem_req_rdy = 1'b0;
    rst = 1'b0;
    #1;
    n_vec++;
    if (dp_if.pc_rst !== 1'b1 || dp_if.mem_req_val !== 1'b0) begin
      n_err++;
      $display("FAIL reset in mem_wait: got pc_rst=%b req=%b want 1,0", dp_if.pc_rst,
               dp_if.mem_req_val);
    end
    next_cycle();
    dp_if.mem_resp_val = 1'b1;
    #1;
    n_vec++;
    if (dp_if.ir_en !== 1'b0 || dp_if.rf_wen !== 1'b0 || dp_if.retire !== 1'b0) begin
      n_err++;
      $display("FAIL late resp in idle: got ir=%b wen=%b ret=%b want 0,0,0", dp_if.ir_en,
               dp_if.rf_wen, dp_if.retire);
    end
    rst = 1'b1;
    next_cycle();
    #1;
    n_vec++;
    if (dp_if.ir_en !== 1'b0 || dp_if.rf_wen !== 1'b0 || dp_if.mem_req_val !== 1'b1 ||
        dp_if.mem_addr_sel !== 1'b0) begin
      n_err++;
      $display("FAIL late resp in fetch: got ir=%b wen=%b req=%b addr_sel=%b want 0,0,1,0",
               dp_if.ir_en, dp_if.rf_wen, dp_if.mem_req_val, dp_if.mem_addr_sel);
    end
    dp_if.mem_resp_val = 1'b0;
    run_inst("post_reset_addi", 32'h0050_0093, 1'b0, 0, 0,
             '{1'b1, WbSelAlu, PcSelPlus4, 1'b1, 1'b0, 3, 0});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_alu();
    test_mem();
    test_jump();
    test_branch();
    test_mul();
    test_back_to_back();
    test_illegal();
    test_reset();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
